// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter and clear sequencer for a single-write-port register file.
// Optional build macro WB_FIXED_PRIO_EN: requester B always wins a tie (no round-robin pointer).
//
// state   | meaning
// CLEAR   | writing 0 to r1..r(NUM_REGS-1), requesters held off
// RUN     | one granted write per cycle, round-robin (or fixed B priority)
module regfile_wb_arbiter #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_rd,
  input  logic [DATA_W-1:0] a_wd,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_rd,
  input  logic [DATA_W-1:0] b_wd,
  output logic              b_ready,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] rd,
  output logic [DATA_W-1:0] WD,
  output logic              init_done
);

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_RUN   = 1'b1;
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(NUM_REGS);

  logic [0:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              reg_write_q, reg_write_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic              grant_a, grant_b;

`ifndef WB_FIXED_PRIO_EN
  logic ptr_q, ptr_d;  // 0: A wins next tie, 1: B wins next tie
`endif

  // No grant while reset is high, so a requester never believes a discarded write was taken.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (state_q == S_RUN && !reset) begin
`ifdef WB_FIXED_PRIO_EN
      grant_b = b_valid;
      grant_a = a_valid & ~b_valid;
`else
      grant_a = a_valid & (~b_valid | ~ptr_q);
      grant_b = b_valid & (~a_valid | ptr_q);
`endif
    end
  end

`ifndef WB_FIXED_PRIO_EN
  always_comb begin
    ptr_d = ptr_q;
    if (grant_a)      ptr_d = 1'b1;
    else if (grant_b) ptr_d = 1'b0;
  end
`endif

  // The counter runs one past the last register so init_done rises the cycle after the final clear write.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    reg_write_d = 1'b0;
    rd_d        = rd_q;
    wd_d        = wd_q;
    case (state_q)
      S_CLEAR: begin
        if (cnt_q >= CNT_END) begin
          state_d = S_RUN;
        end else begin
          reg_write_d = 1'b1;
          rd_d        = cnt_q[ADDR_W-1:0];
          wd_d        = '0;
          cnt_d       = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        if (grant_a) begin
          rd_d        = a_rd;
          wd_d        = a_wd;
          reg_write_d = (a_rd != '0);
        end else if (grant_b) begin
          rd_d        = b_rd;
          wd_d        = b_wd;
          reg_write_d = (b_rd != '0);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_CLEAR;
      cnt_q       <= CNT_W'(1);
      reg_write_q <= 1'b0;
      rd_q        <= '0;
      wd_q        <= '0;
`ifndef WB_FIXED_PRIO_EN
      ptr_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      reg_write_q <= reg_write_d;
      rd_q        <= rd_d;
      wd_q        <= wd_d;
`ifndef WB_FIXED_PRIO_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign a_ready   = grant_a;
  assign b_ready   = grant_b;
  assign RegWrite  = reg_write_q;
  assign rd        = rd_q;
  assign WD        = wd_q;
  assign init_done = (state_q == S_RUN);

endmodule
